// File: rtl/ftdi_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_rx_deframer
// Description : Deframes SYNC/ADDR/DATA_HI/DATA_LO[/CHK] byte frames from an
//               FTDI receive stream into a single-entry command register.
//               Optional XOR checksum byte enabled by FTDI_RX_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_rx_deframer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [7:0]  in_ctrl_data,
    input  logic        in_ctrl_data_rdy,
    output logic        out_ctrl_rx_ena,
    output logic [7:0]  out_cmd_addr,
    output logic [15:0] out_cmd_data,
    output logic        out_cmd_valid,
    input  logic        in_cmd_ready,
    output logic [7:0]  out_err_count
);

`ifdef FTDI_RX_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_ADDR = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CHK  = 3'd4
    } state_t;
    localparam state_t c_LAST_STATE = S_CHK;
`else
    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_ADDR = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3
    } state_t;
    localparam state_t c_LAST_STATE = S_DLO;
`endif

    state_t      r_state;
    logic        r_rdy_d;
    logic        r_byte_vld;
    logic [7:0]  r_byte;
    logic [7:0]  r_addr;
    logic [7:0]  r_dhi;
    logic [15:0] r_tmo_cnt;
    logic [7:0]  r_cmd_addr;
    logic [15:0] r_cmd_data;
    logic        r_cmd_valid;
    logic        r_rx_ena;
    logic [7:0]  r_err_cnt;

    logic        w_edge;
    logic        w_done;
    logic        w_chk_ok;
    logic [15:0] w_frame_data;
    logic        w_good;
    logic        w_chk_err;
    logic        w_accept;
    logic        w_overrun;
    logic [15:0] w_tmo_next;
    logic        w_timeout;
    logic        w_err;

    assign w_edge = in_ctrl_data_rdy & ~r_rdy_d;
    assign w_done = r_byte_vld && (r_state == c_LAST_STATE);

`ifdef FTDI_RX_CHECKSUM_EN
    logic [7:0] r_dlo;
    assign w_chk_ok     = ((r_addr ^ r_dhi ^ r_dlo) == r_byte);
    assign w_frame_data = {r_dhi, r_dlo};
`else
    // Without a checksum the frame ends on DATA_LO, still sitting in r_byte.
    assign w_chk_ok     = 1'b1;
    assign w_frame_data = {r_dhi, r_byte};
`endif

    assign w_good     = w_done & w_chk_ok;
    assign w_chk_err  = w_done & ~w_chk_ok;
    assign w_accept   = r_cmd_valid & in_cmd_ready;
    assign w_overrun  = w_good & r_cmd_valid & ~w_accept;
    assign w_tmo_next = r_tmo_cnt + 16'd1;
    assign w_timeout  = ~r_byte_vld && (r_state != S_HUNT) && (w_tmo_next == TIMEOUT_CYCLES);
    assign w_err      = w_chk_err | w_overrun | w_timeout;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= S_HUNT;
            r_rdy_d     <= 1'b0;
            r_byte_vld  <= 1'b0;
            r_byte      <= 8'h00;
            r_addr      <= 8'h00;
            r_dhi       <= 8'h00;
`ifdef FTDI_RX_CHECKSUM_EN
            r_dlo       <= 8'h00;
`endif
            r_tmo_cnt   <= 16'h0000;
            r_cmd_addr  <= 8'h00;
            r_cmd_data  <= 16'h0000;
            r_cmd_valid <= 1'b0;
            r_rx_ena    <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_rdy_d    <= in_ctrl_data_rdy;
            r_byte_vld <= w_edge;
            if (w_edge) begin
                r_byte <= in_ctrl_data;
            end

            if (r_byte_vld) begin
                r_tmo_cnt <= 16'h0000;
                case (r_state)
                    S_HUNT: begin
                        if (r_byte == SYNC_BYTE) begin
                            r_state <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        r_addr  <= r_byte;
                        r_state <= S_DHI;
                    end
                    S_DHI: begin
                        r_dhi   <= r_byte;
                        r_state <= S_DLO;
                    end
`ifdef FTDI_RX_CHECKSUM_EN
                    S_DLO: begin
                        r_dlo   <= r_byte;
                        r_state <= S_CHK;
                    end
                    S_CHK:   r_state <= S_HUNT;
`else
                    S_DLO:   r_state <= S_HUNT;
`endif
                    default: r_state <= S_HUNT;
                endcase
            end else if (r_state != S_HUNT) begin
                if (w_timeout) begin
                    r_state   <= S_HUNT;
                    r_tmo_cnt <= 16'h0000;
                end else begin
                    r_tmo_cnt <= w_tmo_next;
                end
            end

            // A completing frame may replace a command being accepted this cycle.
            if (w_good && (!r_cmd_valid || w_accept)) begin
                r_cmd_addr  <= r_addr;
                r_cmd_data  <= w_frame_data;
                r_cmd_valid <= 1'b1;
            end else if (w_accept) begin
                r_cmd_valid <= 1'b0;
            end

            r_rx_ena <= ~r_cmd_valid;

            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign out_ctrl_rx_ena = r_rx_ena;
    assign out_cmd_addr    = r_cmd_addr;
    assign out_cmd_data    = r_cmd_data;
    assign out_cmd_valid   = r_cmd_valid;
    assign out_err_count   = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/ftdi_rx_deframer.md
FTDI_RX_DEFRAMER -- requirements
Module: ftdi_rx_deframer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1000, inter-byte timeout in clock cycles (legal 2..65535).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 in_clk  input  1  single clock; all logic on its rising edge.
REQ-004 in_rst  input  1  synchronous, active-high reset.
REQ-005 in_ctrl_data  input  8  received byte from the FTDI controller, valid only while in_ctrl_data_rdy=1.
REQ-006 in_ctrl_data_rdy  input  1  byte-valid strobe, one or more cycles high per byte; each rising edge is one byte.
REQ-007 out_ctrl_rx_ena  output  1  permits the FTDI controller to fetch the next byte.
REQ-008 out_cmd_addr  output  8  decoded command address.
REQ-009 out_cmd_data  output  16  decoded command data, {DATA_HI, DATA_LO}.
REQ-010 out_cmd_valid  output  1  command holding register full.
REQ-011 in_cmd_ready  input  1  consumer accepts the command when high together with out_cmd_valid.
REQ-012 out_err_count  output  8  saturating count of checksum, overrun and timeout errors.

Function
REQ-013 Byte capture SHALL occur on the cycle after a 0->1 transition of in_ctrl_data_rdy; a strobe held high SHALL yield exactly one byte.
REQ-014 Frame format SHALL be SYNC_BYTE, ADDR, DATA_HI, DATA_LO, then CHK when the macro is enabled.
REQ-015 Parser states SHALL be HUNT, ADDR, DHI, DLO, CHK; each captured byte advances exactly one state.
REQ-016 In HUNT, a byte not equal to SYNC_BYTE SHALL be discarded with no error count; a byte equal to SYNC_BYTE SHALL move the parser to ADDR.
REQ-017 A frame SHALL complete on the byte captured in the last state, and the parser SHALL return to HUNT on that same cycle.
REQ-018 A completed, valid frame SHALL load out_cmd_addr and out_cmd_data and set out_cmd_valid on the next cycle, for one cycle of latency from capture of the last byte.
REQ-019 out_cmd_valid SHALL clear on the cycle after in_cmd_ready=1 while out_cmd_valid=1; the outputs SHALL stay stable while valid is high and not yet accepted.
REQ-020 out_ctrl_rx_ena SHALL be the registered value of !out_cmd_valid.
REQ-021 If a frame completes while out_cmd_valid=1 and no acceptance occurs in the same cycle, the frame SHALL be dropped (overrun), out_err_count SHALL increment, and the held command SHALL be kept.
REQ-022 If a frame completes in the same cycle as an acceptance, the new command SHALL be loaded and out_cmd_valid SHALL stay 1.
REQ-023 The timeout counter SHALL reset on every captured byte and count only in states other than HUNT.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES, the parser SHALL go to HUNT, discard the partial frame, and increment out_err_count.
REQ-025 A SYNC_BYTE value received in a state other than HUNT SHALL be treated as ordinary data; there is no resynchronisation.
REQ-026 out_err_count SHALL saturate at 8'hFF.
REQ-027 If several error sources fire in one cycle, out_err_count SHALL increment by 1.

Reset
REQ-028 While in_rst=1: state=HUNT, out_cmd_valid=0, out_cmd_addr=0, out_cmd_data=0, out_err_count=0, timeout counter=0, and the edge-detect register=0.
REQ-029 While in_rst=1, out_ctrl_rx_ena SHALL be 0; it SHALL become 1 on the first cycle after in_rst deasserts.
REQ-030 A reset asserted mid-frame or with a command pending SHALL discard both, and no error SHALL be counted.

Configuration
REQ-031 With macro FTDI_RX_CHECKSUM_EN defined:
- frames are 5 bytes long;
- CHK SHALL equal ADDR ^ DATA_HI ^ DATA_LO;
- a mismatch SHALL drop the frame and increment out_err_count.
REQ-032 With FTDI_RX_CHECKSUM_EN undefined:
- the CHK state and the XOR logic are absent;
- frames are 4 bytes long and complete on DATA_LO.

Verification
REQ-033 FTDI_RX_CHECKSUM_EN on; bytes A5,12,34,56,70 with in_cmd_ready=1 -> one cycle of out_cmd_valid, addr=12, data=3456, err=0.
REQ-034 Bytes 00,FF,A5,01,02,03,02 -> exactly one command with addr=01, data=0203; the leading bytes are ignored and err=0.
REQ-035 Checksum on; A5,12,34,56,00 -> no out_cmd_valid, err=1, and a following good frame is accepted.
REQ-036 Hold in_cmd_ready=0; send two good frames, forcing the second while rx_ena=0 -> the first command is held, err=1, and out_ctrl_rx_ena=0 until acceptance.
REQ-037 TIMEOUT_CYCLES=10; send A5,12, then idle for 10 cycles -> state HUNT and err=1; a following full frame decodes correctly.
REQ-038 Assert in_rst mid-frame after A5,12 -> all outputs return to reset values; then 34,56,... with no SYNC_BYTE -> no command.
